// File: rtl/segment_bus_rr_arbiter.sv
// segment_bus_rr_arbiter
// Round-robin arbiter for one direction (ascending node index) of the segmented
// message chain. Each window it grants every legal request whose node range does
// not overlap an earlier grant in rotating scan order, then holds the resulting
// send/receive/bypass pattern for HOLD_CYCLES cycles.

module segment_bus_rr_arbiter #(
   parameter int NODE_COUNT          = 8,
   parameter int NODE_COUNT_DIGIT    = 3,
   parameter int NODE_TO_ARBITER_SIG = 4,
   parameter int HOLD_CYCLES         = 1
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [NODE_COUNT*NODE_TO_ARBITER_SIG-1:0] request_port,
   output logic [NODE_COUNT*3-1:0]                   control_port,
   output logic                                      busy,
   output logic                                      illegal_req
);

   localparam int                        HOLD_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]         HOLD_LOAD    = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0]         HOLD_ONE     = HOLD_W'(1);
   localparam logic [NODE_COUNT_DIGIT:0] NODE_COUNT_W = (NODE_COUNT_DIGIT + 1)'(NODE_COUNT);
   localparam logic [NODE_COUNT_DIGIT:0] ID_ONE       = (NODE_COUNT_DIGIT + 1)'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [NODE_COUNT_DIGIT-1:0] r_ptr;
   logic [NODE_COUNT_DIGIT-1:0] w_ptr_nxt;
   logic [HOLD_W-1:0]           r_hold_cnt;
   logic [HOLD_W-1:0]           w_hold_cnt_nxt;
   logic [NODE_COUNT*3-1:0]     r_ctrl;
   logic [NODE_COUNT*3-1:0]     w_ctrl_nxt;
   logic                        r_busy;
   logic                        w_busy_nxt;
   logic                        r_illegal;
   logic                        w_illegal_nxt;

   // Per-node request decode: legality and the node masks a grant would claim.
   logic [NODE_COUNT-1:0]       w_legal;
   logic [NODE_COUNT-1:0]       w_illegal;
   logic [NODE_COUNT_DIGIT-1:0] w_dest      [NODE_COUNT];
   logic [NODE_COUNT-1:0]       w_range     [NODE_COUNT];
   logic [NODE_COUNT-1:0]       w_recv_mask [NODE_COUNT];
   logic [NODE_COUNT-1:0]       w_byp_mask  [NODE_COUNT];

   for (genvar k = 0; k < NODE_COUNT; k++) begin : g_node
      logic w_valid;
      assign w_valid      = request_port[NODE_TO_ARBITER_SIG*k + NODE_COUNT_DIGIT];
      assign w_dest[k]    = request_port[NODE_TO_ARBITER_SIG*k +: NODE_COUNT_DIGIT];
      // A transfer only ever moves towards higher indices on this chain.
      assign w_legal[k]   = w_valid && (int'(w_dest[k]) > k) && (int'(w_dest[k]) < NODE_COUNT);
      assign w_illegal[k] = w_valid && (int'(w_dest[k]) <= k);
      for (genvar j = 0; j < NODE_COUNT; j++) begin : g_bit
         assign w_range[k][j]     = (j >= k) && (j <= int'(w_dest[k]));
         assign w_recv_mask[k][j] = (j == int'(w_dest[k]));
         assign w_byp_mask[k][j]  = (j > k) && (j < int'(w_dest[k]));
      end
   end

   // Allocation results for the current IDLE evaluation.
   logic [NODE_COUNT-1:0]       w_claim;
   logic [NODE_COUNT-1:0]       w_send;
   logic [NODE_COUNT-1:0]       w_recv;
   logic [NODE_COUNT-1:0]       w_byp;
   logic                        w_any_grant;
   logic [NODE_COUNT_DIGIT-1:0] w_first_src;
   logic [NODE_COUNT_DIGIT-1:0] w_scan_idx;
   logic [NODE_COUNT_DIGIT:0]   w_scan_sum;

   // Rotating scan from r_ptr: grant each legal request whose range is still unclaimed.
   always_comb begin
      w_claim     = '0;
      w_send      = '0;
      w_recv      = '0;
      w_byp       = '0;
      w_any_grant = 1'b0;
      w_first_src = '0;
      w_scan_sum  = '0;
      w_scan_idx  = '0;
      for (int i = 0; i < NODE_COUNT; i++) begin
         w_scan_sum = {1'b0, r_ptr} + (NODE_COUNT_DIGIT + 1)'(i);
         if (w_scan_sum >= NODE_COUNT_W) begin
            w_scan_sum = w_scan_sum - NODE_COUNT_W;
         end else begin
            w_scan_sum = w_scan_sum;
         end
         w_scan_idx = w_scan_sum[NODE_COUNT_DIGIT-1:0];
         if (w_legal[w_scan_idx] && ((w_range[w_scan_idx] & w_claim) == '0)) begin
            w_claim             = w_claim | w_range[w_scan_idx];
            w_send[w_scan_idx]  = 1'b1;
            w_recv              = w_recv | w_recv_mask[w_scan_idx];
            w_byp               = w_byp | w_byp_mask[w_scan_idx];
            if (!w_any_grant) begin
               w_first_src = w_scan_idx;
            end else begin
               w_first_src = w_first_src;
            end
            w_any_grant = 1'b1;
         end else begin
            w_claim = w_claim;
         end
      end
   end

   // Pointer advances to the node after the first winner, wrapping at NODE_COUNT.
   logic [NODE_COUNT_DIGIT:0] w_ptr_sum;
   logic [NODE_COUNT_DIGIT:0] w_ptr_wrap;
   assign w_ptr_sum  = {1'b0, w_first_src} + ID_ONE;
   assign w_ptr_wrap = (w_ptr_sum >= NODE_COUNT_W) ? (w_ptr_sum - NODE_COUNT_W) : w_ptr_sum;

   // State register: all arbiter state, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_ctrl     <= '0;
         r_busy     <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_busy     <= w_busy_nxt;
         r_illegal  <= w_illegal_nxt;
      end
   end

   // Next-state logic: enter HOLD on any grant, leave it once the hold count expires.
   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_hold_cnt_nxt = r_hold_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_any_grant) begin
               w_state_nxt    = ST_HOLD;
               w_hold_cnt_nxt = HOLD_LOAD;
               w_ptr_nxt      = w_ptr_wrap[NODE_COUNT_DIGIT-1:0];
            end else begin
               w_state_nxt    = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (r_hold_cnt != '0) begin
               w_hold_cnt_nxt = r_hold_cnt - HOLD_ONE;
            end else begin
               w_state_nxt    = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_ptr_nxt      = '0;
            w_hold_cnt_nxt = '0;
         end
      endcase
   end

   // Output logic: next values of the registered control pattern, busy and illegal pulse.
   always_comb begin
      w_ctrl_nxt    = '0;
      w_busy_nxt    = 1'b0;
      w_illegal_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_illegal_nxt = |w_illegal;
            if (w_any_grant) begin
               w_ctrl_nxt = {w_send, w_recv, w_byp};
               w_busy_nxt = 1'b1;
            end else begin
               w_ctrl_nxt = '0;
               w_busy_nxt = 1'b0;
            end
         end
         ST_HOLD: begin
            // Requests are ignored while a window is in progress.
            if (r_hold_cnt != '0) begin
               w_ctrl_nxt = r_ctrl;
               w_busy_nxt = 1'b1;
            end else begin
               w_ctrl_nxt = '0;
               w_busy_nxt = 1'b0;
            end
         end
         default: begin
            w_ctrl_nxt    = '0;
            w_busy_nxt    = 1'b0;
            w_illegal_nxt = 1'b0;
         end
      endcase
   end

   assign control_port = r_ctrl;
   assign busy         = r_busy;
   assign illegal_req  = r_illegal;

endmodule
